paddsb_accum: RTL and testbench
===============================

# paddsb_accum

Multi-cycle sequencer that owns one saturating nibble adder (`PADDSB`) and uses it to reduce a stream of 16-bit words into a single packed result: four independent signed 4-bit lanes, each saturating to 0x7 or 0x8. It sits beside the ALU as a small accelerator. A start command loads a seed and a word count, words arrive on a valid/ready stream, and the block reports the final packed sum plus per-lane sticky saturation flags.

## Interface
- `CNT_W`, 4, width of the word-count field (max burst = 2^CNT_W − 1 words)
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  command strobe; accepted only in IDLE
- `seed`  in  16  initial accumulator value, sampled with an accepted `start`
- `len`  in  CNT_W  number of words to accumulate, sampled with an accepted `start`
- `in_valid`  in  1  `in_data` is valid
- `in_ready`  out  1  block accepts a word this cycle
- `in_data`  in  16  four packed signed nibbles, lane 0 = [3:0]
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle completion pulse
- `acc_out`  out  16  accumulator; final result valid from `done` until the next accepted `start`
- `sat_flags`  out  4  sticky per-lane saturation flags for the current run; bit i = lane i

## Operation
- States are IDLE, ACCUM and DONE.
- **IDLE:** `busy`=0, `in_ready`=0.
  - `start`=1 is accepted: `acc` ← `seed`, `cnt` ← `len`, `sat_flags` ← 0.
  - If `len`≠0 the next state is ACCUM; if `len`=0 the next state is DONE.
- **ACCUM:** `in_ready`=1. A beat is accepted when `in_valid`&&`in_ready`.
  - On an accepted beat: `acc` ← `PADDSB(acc, in_data)`, `cnt` ← `cnt`−1, and `sat_flags` |= the lane overflow vector.
  - When the beat that brings `cnt` from 1 to 0 is accepted, the next state is DONE.
  - With no accepted beat, all state holds.
  - `start` is ignored in this state.
- **DONE:** `done`=1, `busy`=1, `in_ready`=0. Next state is unconditionally IDLE. `start` is ignored in this state.
- **Lane overflow (computed in the controller; `PADDSB` exports no flag):** lane i overflows when `acc`[4i+3] == `in_data`[4i+3] and bit 3 of the raw 4-bit sum `acc`[4i+3:4i]+`in_data`[4i+3:4i] differs from that sign.
- **Arithmetic rules:**
  - No carry crosses a lane boundary.
  - A saturated lane keeps participating, so a later opposite-sign word can bring it back into range.
  - `sat_flags` stays set until the next accepted `start`.
- **Reset:** a synchronous `rst` at any point, including mid-burst, forces IDLE with `acc_out`=0, `sat_flags`=0, `cnt`=0, `done`=0, `busy`=0, `in_ready`=0. Partial results are discarded.

## Timing
- `in_ready` is a registered function of state only; it never depends combinationally on `in_valid`.
- Throughput is one word per cycle with `in_valid` held high.
- Latency for `len`=N with no stalls:
  - `start` is accepted in cycle 0.
  - Beats are accepted in cycles 1..N.
  - `done` is high in cycle N+1, with the final `acc_out` valid in that same cycle.
  - The block is back in IDLE at cycle N+2 and can accept `start` there.
- For `len`=0, `done` is high in cycle 1 and `acc_out`=`seed`.
- `acc_out` and `sat_flags` are registered and update the cycle after each accepted beat.

## Structure
- State encodings (IDLE=2'b00, ACCUM=2'b01, DONE=2'b10) and the lane constants (SAT_POS=4'h7, SAT_NEG=4'h8, LANES=4) go in the shared defines file used by the ALU blocks.
- There is exactly one sub-module: a single `PADDSB` instance with inputs `acc` and `in_data`.
- The lane-overflow detect is four small combinational terms inside this block.

## Test plan
- **Basic sum:** seed 0x0000, len 2, words 0x1234 then 0x1111 → `done` in cycle 3, `acc_out`=0x2345, `sat_flags`=0000.
- **Positive saturation:** seed 0x7777, len 1, word 0x1111 → `acc_out`=0x7777, `sat_flags`=1111.
- **Mixed lanes:** seed 0x7F00, len 1, word 0x1F00 → `acc_out`=0x7E00, `sat_flags`=1000. Then seed 0x8888, len 1, word 0xFFFF → `acc_out`=0x8888, `sat_flags`=1111.
- **Zero length:** seed 0xABCD, len 0 → `done` in cycle 1, `acc_out`=0xABCD, `in_ready` never high.
- **Backpressure and ignored start:** len 3, with `in_valid` low in alternate cycles and `start` pulsed during ACCUM → exactly 3 beats consumed, `start` ignored, `done` pulses once, and the result equals the saturating sum of the three words.
- **Reset mid-burst:** `rst` asserted after 1 of 3 beats → next cycle IDLE with all outputs zero. A new start with len 1, seed 0, word 0x0001 → `acc_out`=0x0001.

Source files
------------

// File: rtl/paddsb_accum_pkg.sv
// Shared definitions for the packed-nibble saturating accumulator:
// state encodings, lane constants and the per-lane overflow term.
package paddsb_accum_pkg;

  localparam int         LANES   = 4;
  localparam logic [3:0] SAT_POS = 4'h7;
  localparam logic [3:0] SAT_NEG = 4'h8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Signed 4-bit overflow: operands agree in sign, wrapped sum does not.
  function automatic logic lane_ovf(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] raw;
    raw = a + b;
    return (a[3] == b[3]) && (raw[3] != a[3]);
  endfunction

endpackage

// File: rtl/paddsb_accum_paddsb.sv
// Four-lane signed saturating nibble adder; lanes are fully independent.
module paddsb_accum_paddsb
  import paddsb_accum_pkg::*;
(
  input  logic [15:0] acc,
  input  logic [15:0] in_data,
  output logic [15:0] sum
);

  logic [3:0] raw_s;

  // Per-lane wrap-around add, clamped to the sign of the operands on overflow
  always_comb begin
    sum   = 16'h0000;
    raw_s = 4'h0;
    for (int i = 0; i < LANES; i++) begin
      raw_s = acc[4*i +: 4] + in_data[4*i +: 4];
      if (lane_ovf(acc[4*i +: 4], in_data[4*i +: 4])) begin
        sum[4*i +: 4] = acc[4*i+3] ? SAT_NEG : SAT_POS;
      end else begin
        sum[4*i +: 4] = raw_s;
      end
    end
  end

endmodule

// File: rtl/paddsb_accum.sv
// Sequencer that folds a counted burst of packed-nibble words into one
// saturating sum, with sticky per-lane saturation flags.
module paddsb_accum
  import paddsb_accum_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      seed,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  output logic             busy,
  output logic             done,
  output logic [15:0]      acc_out,
  output logic [3:0]       sat_flags
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r, state_s;
  logic [15:0]      acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       sat_r;
  logic             ready_r, busy_r, done_r;
  logic [15:0]      sum_s;
  logic [3:0]       ovf_s;
  logic             beat_s, accept_s;

  paddsb_accum_paddsb u_paddsb (
    .acc     (acc_r),
    .in_data (in_data),
    .sum     (sum_s)
  );

  assign beat_s   = (state_r == ACCUM) && in_valid && ready_r;
  assign accept_s = (state_r == IDLE) && start;

  // Lane overflow vector seen by the current beat
  always_comb begin
    ovf_s = 4'b0000;
    for (int i = 0; i < LANES; i++) begin
      ovf_s[i] = lane_ovf(acc_r[4*i +: 4], in_data[4*i +: 4]);
    end
  end

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (len != CNT_ZERO) ? ACCUM : DONE;
        end else begin
          state_s = IDLE;
        end
      end
      ACCUM: begin
        if (beat_s && (cnt_r == CNT_ONE)) begin
          state_s = DONE;
        end else begin
          state_s = ACCUM;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, datapath and registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      acc_r   <= 16'h0000;
      cnt_r   <= CNT_ZERO;
      sat_r   <= 4'b0000;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      ready_r <= (state_s == ACCUM);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
      if (accept_s) begin
        acc_r <= seed;
        cnt_r <= len;
        sat_r <= 4'b0000;
      end else if (beat_s) begin
        acc_r <= sum_s;
        cnt_r <= cnt_r - CNT_ONE;
        sat_r <= sat_r | ovf_s;
      end else begin
        acc_r <= acc_r;
        cnt_r <= cnt_r;
        sat_r <= sat_r;
      end
    end
  end

  assign in_ready  = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign acc_out   = acc_r;
  assign sat_flags = sat_r;

endmodule

// File: tb/tb_paddsb_accum.sv
// Directed bench for paddsb_accum: inputs change and outputs are sampled
// on the falling edge, expected values are worked out by hand.
module tb_paddsb_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] seed;
  logic [3:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        busy;
  logic        done;
  logic [15:0] acc_out;
  logic [3:0]  sat_flags;

  int vectors     = 0;
  int miscompares = 0;

  paddsb_accum #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed      (seed),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .busy      (busy),
    .done      (done),
    .acc_out   (acc_out),
    .sat_flags (sat_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a start command for one cycle; returns one cycle after acceptance.
  task automatic start_cmd(input logic [15:0] s, input logic [3:0] n);
    start = 1'b1;
    seed  = s;
    len   = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; seed = 16'h0000; len = 4'd0;
    in_valid = 1'b0; in_data = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_acc",   acc_out,           16'h0000);
    chk("rst_sat",   {12'h000, sat_flags}, 16'h0000);
    chk("rst_flags", {13'h0000, busy, done, in_ready}, 16'h0000);

    // Basic sum: done three cycles after the accepted start
    start_cmd(16'h0000, 4'd2);
    chk("basic_accum_flags", {13'h0000, busy, done, in_ready}, 16'h0005);
    beat(16'h1234);
    chk("basic_partial", acc_out, 16'h1234);
    beat(16'h1111);
    chk("basic_done",  {15'h0000, done}, 16'h0001);
    chk("basic_acc",   acc_out, 16'h2345);
    chk("basic_sat",   {12'h000, sat_flags}, 16'h0000);
    @(negedge clk);
    chk("basic_idle",  {13'h0000, busy, done, in_ready}, 16'h0000);

    // Positive saturation in every lane
    start_cmd(16'h7777, 4'd1);
    beat(16'h1111);
    chk("pos_acc", acc_out, 16'h7777);
    chk("pos_sat", {12'h000, sat_flags}, 16'h000F);
    @(negedge clk);

    // Mixed lanes, then negative saturation; flags cleared by the new start
    start_cmd(16'h7F00, 4'd1);
    chk("mixed_sat_cleared", {12'h000, sat_flags}, 16'h0000);
    beat(16'h1F00);
    chk("mixed_acc", acc_out, 16'h7E00);
    chk("mixed_sat", {12'h000, sat_flags}, 16'h0008);
    @(negedge clk);
    start_cmd(16'h8888, 4'd1);
    beat(16'hFFFF);
    chk("neg_acc", acc_out, 16'h8888);
    chk("neg_sat", {12'h000, sat_flags}, 16'h000F);
    @(negedge clk);

    // Zero length: done in the cycle right after start, no ready
    start_cmd(16'hABCD, 4'd0);
    chk("zero_flags", {13'h0000, busy, done, in_ready}, 16'h0006);
    chk("zero_acc",   acc_out, 16'hABCD);
    @(negedge clk);
    chk("zero_idle",  {13'h0000, busy, done, in_ready}, 16'h0000);

    // Backpressure with a start pulse mid-burst; lane 3 saturates then recovers
    start_cmd(16'h1230, 4'd3);
    start = 1'b1; seed = 16'hFFFF; len = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk("bp_start_ignored", acc_out, 16'h1230);
    beat(16'h3456);
    chk("bp_beat1", acc_out, 16'h4676);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("bp_stall_hold", acc_out, 16'h4676);
    beat(16'h4000);
    chk("bp_beat2", acc_out, 16'h7676);
    chk("bp_sat2",  {12'h000, sat_flags}, 16'h000A);
    @(negedge clk);
    chk("bp_stall_nodone", {15'h0000, done}, 16'h0000);
    beat(16'hF00F);
    chk("bp_done", {13'h0000, busy, done, in_ready}, 16'h0006);
    chk("bp_acc",  acc_out, 16'h6675);
    chk("bp_sat",  {12'h000, sat_flags}, 16'h000A);
    in_valid = 1'b1; in_data = 16'h1111;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_single_done", {13'h0000, busy, done, in_ready}, 16'h0000);
    chk("bp_acc_held", acc_out, 16'h6675);

    // Reset after the first of three beats discards the run
    start_cmd(16'h1111, 4'd3);
    beat(16'h2222);
    chk("rst_mid_partial", acc_out, 16'h3333);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_acc",   acc_out, 16'h0000);
    chk("rst_mid_flags", {9'h000, sat_flags, busy, done, in_ready}, 16'h0000);
    start_cmd(16'h0000, 4'd1);
    beat(16'h0001);
    chk("after_rst_done", {15'h0000, done}, 16'h0001);
    chk("after_rst_acc",  acc_out, 16'h0001);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
